// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction/data memory with a fixed read
// latency. Writes complete in one cycle. Reads return after LAT cycles.
// Misaligned requests and simultaneous rd+wr requests produce an error pulse.
module imem_responder #(
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [AW-1:0]   ridx;
    logic [15:0]     mem [2**AW];

    logic [AW-1:0]   idx;
    logic            accept;
    logic            bad;
    logic            wr_ok;
    logic            unused_addr_hi;

    // Byte address to word index; the upper bits alias (wrap).
    assign idx            = addr[AW:1];
    assign unused_addr_hi = ^addr[15:AW+1];

    // A request is only looked at in IDLE and outside reset.
    assign accept = (state == IDLE) && !rst && (rd || wr);
    assign bad    = (rd && wr) || addr[0];
    assign wr_ok  = accept && !bad && wr;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[idx] <= data_in;
    end

    // Control FSM: accepts requests in IDLE and times reads with a down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            ridx     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            stall    <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else if (wr) begin
                            done <= 1'b1;
                        end else if (LAT == 1) begin
                            // Single-cycle read: no BUSY state needed.
                            data_out <= mem[idx];
                            done     <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= 3'(LAT - 1);
                            ridx  <= idx;
                            stall <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Requests here are ignored; the array cannot change while busy.
                    if (cnt == 3'd1) begin
                        data_out <= mem[ridx];
                        done     <= 1'b1;
                        stall    <= 1'b0;
                        cnt      <= 3'd0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning read latency in cycles, legal range 1..7.
REQ-002 SHALL have parameter AW, default 8, meaning word-index width; the array holds 2^AW 16-bit words.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rd  input  1  read request, sampled at the clk edge.
REQ-006 SHALL have port wr  input  1  write request, sampled at the clk edge.
REQ-007 SHALL have port addr  input  16  byte address.
REQ-008 SHALL have port data_in  input  16  write data.
REQ-009 SHALL have port data_out  output  16  read data, valid while done=1.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port stall  output  1  busy; the requester holds its request while stall=1.
REQ-012 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and BUSY, with a 3-bit down-counter.
REQ-014 SHALL index the array with addr[AW:1]; upper address bits are ignored, so addresses wrap modulo 2^(AW+1) bytes.
REQ-015 SHALL accept requests only at an edge where the state is IDLE; rd/wr sampled in BUSY are ignored, with no side effects.
REQ-016 SHALL treat a request with addr[0]=1 as misaligned: no array access; err=1 and done=0 in the next cycle; the state stays IDLE.
REQ-017 SHALL treat rd=1 and wr=1 at the same edge as illegal: no access; err=1 in the next cycle; the state stays IDLE.
REQ-018 SHALL, for an aligned write accepted at edge t, update the array at edge t and drive done=1 in cycle t+1 independent of LAT; data_out is unchanged.
REQ-019 SHALL, for an aligned read accepted at edge t, capture the word index at edge t and drive done=1 with data_out = the array word in cycle t+LAT.
REQ-020 SHALL drive stall=1 in cycles t+1..t+LAT-1 of an accepted read, so LAT=1 gives zero stall cycles.
REQ-021 SHALL be in IDLE with stall=0 during the done cycle of a read, so a request sampled at the edge ending that cycle is accepted (back-to-back throughput of one read per LAT cycles).
REQ-022 SHALL return the array word as it stands at the edge ending the last BUSY cycle.
REQ-023 SHALL hold data_out at its last read value until the next read done; done, err and stall SHALL be registered outputs.
REQ-024 SHALL never assert done and err in the same cycle.

Reset
REQ-025 SHALL, when rst=1 at an edge, set state=IDLE, counter=0, done=0, err=0, stall=0, data_out=0x0000.
REQ-026 SHALL NOT clear array contents on reset.
REQ-027 SHALL, on rst during BUSY, abort the read with no done pulse ever produced for it; the first edge with rst=0 accepts new requests.
REQ-028 SHALL ignore rd/wr at any edge where rst=1.

Verification
REQ-029 Bench SHALL cover: LAT=2; write 0xBEEF to addr 0x0010, then read 0x0010 -> write done in the next cycle; read gives stall=1 for 1 cycle, then done=1 with data_out=0xBEEF.
REQ-030 Bench SHALL cover: LAT=1; back-to-back reads of 0x0000 and 0x0002 (holding 0x1111, 0x2222) -> done on two consecutive cycles with 0x1111 then 0x2222, stall always 0.
REQ-031 Bench SHALL cover: a read of 0x0003 -> err=1 for one cycle, done=0, data_out keeps its previous value.
REQ-032 Bench SHALL cover: AW=8; read 0x0204 after writing 0xCAFE to 0x0004 -> data_out=0xCAFE (wrap).
REQ-033 Bench SHALL cover: LAT=4; read issued, rst=1 during the second stall cycle -> no done; all outputs are 0 after the reset edge, and the array is intact on re-read.
REQ-034 Bench SHALL cover: rd=wr=1 in IDLE -> err pulse, array unchanged; rd asserted during BUSY -> ignored, only one done produced.
